// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational circular priority search: first set req bit starting at last+1.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = last + SEL_W'(k);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select and one-hot grant.
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("mux4_rr_arbiter supports exactly 4 requesters");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter MAX_HOLD must be within 1..255");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [3:0]         r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic               r_busy;
    logic               r_timeout;
    logic [SEL_W-1:0]   r_last;

    logic               w_found;
    logic [SEL_W-1:0]   w_win;
    logic               w_release;
    logic               w_hold_hit;
    logic               w_force;

    logic [3:0]         w_grant_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;
    logic [SEL_W-1:0]   w_last_nxt;

    rr_pick4 u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_win)
    );

    // r_sel always names the owner while in GRANT
    assign w_release = done[r_sel] | ~req[r_sel];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold;

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + 8'd1;
        end
    end

    assign w_hold_hit = (r_hold == HOLD_LAST);
`else
    assign w_hold_hit = 1'b0;
`endif

    // a normal release wins over a forced one
    assign w_force = w_hold_hit & ~w_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= 2'd3;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_last    <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = GRANT;
            GRANT:   if (w_release || w_force) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt   = r_grant;
        w_sel_nxt     = r_sel;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_last_nxt    = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = onehot4(w_win);
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = w_win;
                end
            end
            GRANT: begin
                if (w_release || w_force) begin
                    w_grant_nxt   = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = w_force;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (timeout checks follow ARB_TIMEOUT_EN).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_tests;
    int n_fail;

    mux4_rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one edge; sample and drive 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({grant, sel, busy, timeout} !== {4'b0000, 2'b00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: grant/sel/busy/timeout=%b/%b/%b/%b expected 0000/00/0/0",
                     grant, sel, busy, timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        n_tests++;
        if ({grant, sel, busy} !== {4'b0100, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: grant/sel/busy=%b/%b/%b expected 0100/10/1", grant, sel, busy);
        end
        done = 4'b0100;
        tick();
        done = '0;
        n_tests++;
        if ({grant, busy} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_release: grant/busy=%b/%b expected 0000/0", grant, busy);
        end
    endtask

    task automatic test_all_requesting();
        logic [1:0] e;
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            n_tests++;
            if ({grant, sel, busy} !== {4'b0001 << e, e, 1'b1}) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: grant/sel/busy=%b/%b/%b expected %b/%b/1",
                         i, grant, sel, busy, 4'b0001 << e, e);
            end
            tick();
            tick();
            n_tests++;
            if (grant !== (4'b0001 << e)) begin
                n_fail++;
                $display("FAIL rr_hold[%0d]: grant=%b expected %b", i, grant, 4'b0001 << e);
            end
            done = 4'b0001 << e;
            tick();
            done = '0;
            n_tests++;
            if ({grant, busy} !== {4'b0000, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_bubble[%0d]: grant/busy=%b/%b expected 0000/0", i, grant, busy);
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_non_owner();
        do_reset();
        req = 4'b0110;
        tick();
        done = 4'b0001;
        req  = 4'b0010;
        tick();
        n_tests++;
        if ({grant, sel, busy} !== {4'b0010, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL non_owner: grant/sel/busy=%b/%b/%b expected 0010/01/1", grant, sel, busy);
        end
        tick();
        n_tests++;
        if ({grant, sel} !== {4'b0010, 2'b01}) begin
            n_fail++;
            $display("FAIL non_owner_hold: grant/sel=%b/%b expected 0010/01", grant, sel);
        end
        done = '0;
    endtask

    task automatic test_owner_drop();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0001;
        tick();
        n_tests++;
        if ({grant, sel, busy} !== {4'b0000, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL owner_drop: grant/sel/busy=%b/%b/%b expected 0000/10/0", grant, sel, busy);
        end
        req = 4'b0101;
        tick();
        n_tests++;
        if ({grant, sel} !== {4'b0001, 2'b00}) begin
            n_fail++;
            $display("FAIL wrap_grant: grant/sel=%b/%b expected 0001/00", grant, sel);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b1011;
        tick();
        n_tests++;
        if ({grant, sel} !== {4'b1000, 2'b11}) begin
            n_fail++;
            $display("FAIL simultaneous: grant/sel=%b/%b expected 1000/11", grant, sel);
        end
    endtask

    task automatic test_rewin();
        do_reset();
        req = 4'b0001;
        tick();
        done = 4'b0001;
        tick();
        done = '0;
        tick();
        n_tests++;
        if ({grant, busy} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL rewin_alone: grant/busy=%b/%b expected 0001/1", grant, busy);
        end
    endtask

    task automatic test_done_idle();
        do_reset();
        done = 4'b1111;
        tick();
        tick();
        n_tests++;
        if ({grant, busy} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL done_idle: grant/busy=%b/%b expected 0000/0", grant, busy);
        end
        done = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        n_tests++;
        if ({grant, busy, sel} !== {4'b0000, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid3: grant/busy/sel=%b/%b/%b expected 0000/0/00", grant, busy, sel);
        end
        tick();
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_next3: grant=%b expected 0001", grant);
        end
        // owner 0 leaves last=0; only a restored pointer picks 0 over 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
        n_tests++;
        if ({grant, sel} !== {4'b0001, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_ptr: grant/sel=%b/%b expected 0001/00", grant, sel);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({grant, timeout} !== {4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL to_hold[%0d]: grant/timeout=%b/%b expected 0001/0", i, grant, timeout);
            end
        end
        tick();
        n_tests++;
        if ({grant, busy, timeout} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL to_fire: grant/busy/timeout=%b/%b/%b expected 0000/0/1", grant, busy, timeout);
        end
        tick();
        n_tests++;
        if ({grant, sel, timeout} !== {4'b0010, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL to_next: grant/sel/timeout=%b/%b/%b expected 0010/01/0", grant, sel, timeout);
        end
        tick();
        tick();
        tick();
        done = 4'b0010;
        tick();
        done = '0;
        n_tests++;
        if ({grant, timeout} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL to_precedence: grant/timeout=%b/%b expected 0000/0", grant, timeout);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if ({grant, timeout} !== {4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL no_timeout[%0d]: grant/timeout=%b/%b expected 0001/0", i, grant, timeout);
            end
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        req     = '0;
        done    = '0;
        test_reset();
        test_single();
        test_all_requesting();
        test_non_owner();
        test_owner_drop();
        test_simultaneous();
        test_rewin();
        test_done_idle();
        test_reset_mid_grant();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
